reaction_measure: RTL and testbench

REACTION_MEASURE -- requirements
Module: reaction_measure

---
 rtl/reaction_measure.sv | 89 ++++++++
 tb/tb_reaction_measure.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/reaction_measure.sv
// reaction_measure: reaction timer (binary + BCD ms) with false-start, too-slow and best-time tracking
// ports: clock/reset (sync, active-high); rising_edge_1khz ms strobe; current_state top-level state;
//        button debounced level; reaction_ms/reaction_bcd measured time; result_valid held result;
//        press_done end-of-measurement pulse; false_start/too_slow sticky flags; best_ms fastest valid time
`ifndef STATE_IDLE
`define STATE_IDLE 3'd0
`endif
`ifndef STATE_PREP
`define STATE_PREP 3'd1
`endif
`ifndef STATE_TEST
`define STATE_TEST 3'd2
`endif
module reaction_measure #(
  parameter int MAX_MS = 9999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rising_edge_1khz,
  input  logic [2:0]  current_state,
  input  logic        button,
  output logic [13:0] reaction_ms,
  output logic [15:0] reaction_bcd,
  output logic        result_valid,
  output logic        press_done,
  output logic        false_start,
  output logic        too_slow,
  output logic [13:0] best_ms
);
  localparam logic [13:0] MAX = 14'(MAX_MS);
  typedef enum logic [1:0] {M_IDLE, M_RUN, M_HOLD} mstate_t;
  mstate_t state, state_nx;
  logic btn_q, pe, in_test, at_max, run_ok, start, fin_press, fin_slow, tick, go_idle, fs_set, c;
  logic [15:0] bcd_inc;
  assign pe      = button & ~btn_q;
  assign in_test = current_state == `STATE_TEST;
  assign at_max  = reaction_ms == MAX;
  always_ff @(posedge clock)
    if (reset) state <= M_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      M_IDLE:  state_nx = (in_test && !false_start) ? M_RUN : M_IDLE;
      M_RUN:   state_nx = !in_test ? M_IDLE : (pe || at_max) ? M_HOLD : M_RUN;
      M_HOLD:  state_nx = (current_state == `STATE_IDLE) ? M_IDLE : M_HOLD;
      default: state_nx = M_IDLE;
    endcase
  end
  // a press beats both the ceiling and a coincident strobe
  always_comb begin
    run_ok    = state == M_RUN && in_test;
    start     = state == M_IDLE && in_test && !false_start;
    fin_press = run_ok && pe;
    fin_slow  = run_ok && !pe && at_max;
    tick      = run_ok && !pe && !at_max && rising_edge_1khz;
    go_idle   = state != M_RUN && current_state == `STATE_IDLE;
    fs_set    = state == M_IDLE && current_state == `STATE_PREP && pe;
  end
  always_comb begin
    c = 1'b1;
    bcd_inc = reaction_bcd;
    for (int i = 0; i < 4; i++) begin
      bcd_inc[4*i +: 4] = c ? (reaction_bcd[4*i +: 4] == 4'd9 ? 4'd0 : reaction_bcd[4*i +: 4] + 4'd1)
                            : reaction_bcd[4*i +: 4];
      c = c && reaction_bcd[4*i +: 4] == 4'd9;
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      btn_q        <= 1'b0;
      reaction_ms  <= '0;
      reaction_bcd <= '0;
      result_valid <= 1'b0;
      press_done   <= 1'b0;
      false_start  <= 1'b0;
      too_slow     <= 1'b0;
      best_ms      <= MAX;
    end else begin
      btn_q        <= button;
      press_done   <= fin_press | fin_slow;
      reaction_ms  <= start ? '0 : tick ? reaction_ms + 14'd1 : reaction_ms;
      reaction_bcd <= start ? '0 : tick ? bcd_inc : reaction_bcd;
      result_valid <= (start || go_idle) ? 1'b0 : (fin_press || fin_slow) ? 1'b1 : result_valid;
      too_slow     <= (start || go_idle) ? 1'b0 : fin_slow ? 1'b1 : too_slow;
      false_start  <= go_idle ? 1'b0 : fs_set ? 1'b1 : false_start;
      best_ms      <= (press_done && !too_slow && reaction_ms < best_ms) ? reaction_ms : best_ms;
    end
endmodule

// File: tb/tb_reaction_measure.sv
// tb_reaction_measure: directed scoreboard bench for reaction_measure
`ifndef STATE_IDLE
`define STATE_IDLE 3'd0
`endif
`ifndef STATE_PREP
`define STATE_PREP 3'd1
`endif
`ifndef STATE_TEST
`define STATE_TEST 3'd2
`endif
module tb_reaction_measure;
  logic clock = 1'b0, reset = 1'b1, rising_edge_1khz = 1'b0, button = 1'b0;
  logic [2:0] current_state = `STATE_IDLE;
  logic [13:0] reaction_ms, best_ms;
  logic [15:0] reaction_bcd;
  logic result_valid, press_done, false_start, too_slow;
  logic prev_pd = 1'b0;
  int checks = 0, failures = 0;
  typedef struct packed {logic [13:0] ms; logic [15:0] bcd; logic slow;} exp_t;
  exp_t q[$];
  always #5 clock = ~clock;
  reaction_measure #(.MAX_MS(9999)) dut (
    .clock(clock), .reset(reset), .rising_edge_1khz(rising_edge_1khz),
    .current_state(current_state), .button(button), .reaction_ms(reaction_ms),
    .reaction_bcd(reaction_bcd), .result_valid(result_valid), .press_done(press_done),
    .false_start(false_start), .too_slow(too_slow), .best_ms(best_ms)
  );
  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
    if (press_done) begin
      chk("sb_has_entry", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("done_ms", reaction_ms, e.ms);
        chk("done_bcd", reaction_bcd, e.bcd);
        chk("done_too_slow", too_slow, e.slow);
      end
    end
    chk("press_done_consecutive", prev_pd & press_done, 0);
    prev_pd = press_done;
  endtask
  task automatic strobes(input int n);
    repeat (n) begin
      rising_edge_1khz = 1'b1;
      cyc();
      rising_edge_1khz = 1'b0;
      cyc();
    end
  endtask
  task automatic trial(input int n, input int exp_best);
    current_state = `STATE_TEST;
    cyc();
    strobes(n);
    q.push_back({14'(n), to_bcd(n), 1'b0});
    button = 1'b1;
    cyc();
    chk("trial_done_seen", q.size(), 0);
    chk("trial_valid", result_valid, 1);
    cyc();
    chk("trial_best", best_ms, exp_best);
    chk("trial_hold_ms", reaction_ms, n);
    button = 1'b0;
    current_state = `STATE_IDLE;
    cyc();
    chk("trial_valid_cleared", result_valid, 0);
    chk("trial_retain_ms", reaction_ms, n);
  endtask
  initial begin
    cyc();
    cyc();
    chk("rst_ms", reaction_ms, 0);
    chk("rst_bcd", reaction_bcd, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_done", press_done, 0);
    chk("rst_fs", false_start, 0);
    chk("rst_slow", too_slow, 0);
    chk("rst_best", best_ms, 9999);
    reset = 1'b0;
    cyc();
    trial(237, 237);
    trial(412, 237);
    trial(150, 150);
    current_state = `STATE_PREP;
    cyc();
    button = 1'b1;
    cyc();
    chk("fs_set", false_start, 1);
    button = 1'b0;
    current_state = `STATE_TEST;
    cyc();
    strobes(5);
    button = 1'b1;
    cyc();
    cyc();
    chk("fs_no_valid", result_valid, 0);
    chk("fs_sticky", false_start, 1);
    chk("fs_no_run", reaction_ms, 150);
    button = 1'b0;
    current_state = `STATE_IDLE;
    cyc();
    chk("fs_cleared", false_start, 0);
    current_state = `STATE_TEST;
    cyc();
    q.push_back({14'd9999, 16'h9999, 1'b1});
    strobes(9999);
    chk("slow_done_seen", q.size(), 0);
    chk("slow_flag", too_slow, 1);
    chk("slow_best", best_ms, 150);
    rising_edge_1khz = 1'b1;
    button = 1'b1;
    cyc();
    rising_edge_1khz = 1'b0;
    cyc();
    chk("slow_hold_ms", reaction_ms, 9999);
    chk("slow_hold_bcd", reaction_bcd, 16'h9999);
    chk("slow_best_after", best_ms, 150);
    current_state = `STATE_IDLE;
    cyc();
    chk("slow_cleared", too_slow, 0);
    current_state = `STATE_TEST;
    cyc();
    strobes(99);
    chk("held_no_done", result_valid, 0);
    button = 1'b0;
    cyc();
    chk("held_count", reaction_ms, 99);
    q.push_back({14'd99, 16'h0099, 1'b0});
    button = 1'b1;
    rising_edge_1khz = 1'b1;
    cyc();
    rising_edge_1khz = 1'b0;
    chk("tie_done_seen", q.size(), 0);
    cyc();
    chk("tie_ms", reaction_ms, 99);
    chk("tie_bcd", reaction_bcd, 16'h0099);
    chk("tie_best", best_ms, 99);
    button = 1'b0;
    current_state = `STATE_IDLE;
    cyc();
    current_state = `STATE_TEST;
    cyc();
    strobes(20);
    current_state = `STATE_PREP;
    cyc();
    button = 1'b1;
    cyc();
    cyc();
    chk("abort_valid", result_valid, 0);
    chk("abort_ms", reaction_ms, 20);
    chk("abort_fs", false_start, 1);
    button = 1'b0;
    current_state = `STATE_IDLE;
    cyc();
    current_state = `STATE_TEST;
    cyc();
    strobes(500);
    chk("mid_count", reaction_ms, 500);
    chk("mid_bcd", reaction_bcd, 16'h0500);
    reset = 1'b1;
    button = 1'b1;
    cyc();
    chk("mrst_ms", reaction_ms, 0);
    chk("mrst_bcd", reaction_bcd, 0);
    chk("mrst_valid", result_valid, 0);
    chk("mrst_done", press_done, 0);
    chk("mrst_fs", false_start, 0);
    chk("mrst_slow", too_slow, 0);
    chk("mrst_best", best_ms, 9999);
    current_state = `STATE_IDLE;
    button = 1'b0;
    reset = 1'b0;
    cyc();
    cyc();
    chk("mrst_no_done", press_done, 0);
    chk("sb_empty_end", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
